// File: rtl/axi_llc_pkg.sv
// LLC shared types: descriptor layout and scheduler state/source encodings.
// Imported by the descriptor scheduler and its neighbours.
package axi_llc_pkg;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        FLUSH
    } sched_state_e;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_AW,
        SRC_AR,
        SRC_FLUSH
    } sched_src_e;

    typedef struct packed {
        logic [15:0] addr;
        logic [3:0]  id;
        logic        rw;
        logic        x_last;
    } llc_desc_t;

endpackage

// File: rtl/axi_llc_desc_scheduler.sv
// Descriptor scheduler: burst-bound AW/AR round-robin in front of the
// descriptor pipeline, plus flush sequencing (gate, drain, flush window).
module axi_llc_desc_scheduler
    import axi_llc_pkg::*;
#(
    parameter type  desc_t   = llc_desc_t,
    parameter logic RrInitAw = 1'b1
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  desc_t aw_desc_i,
    input  logic  aw_valid_i,
    output logic  aw_ready_o,
    input  logic  aw_busy_i,
    input  desc_t ar_desc_i,
    input  logic  ar_valid_i,
    output logic  ar_ready_o,
    input  logic  ar_busy_i,
    input  desc_t flush_desc_i,
    input  logic  flush_valid_i,
    output logic  flush_ready_o,
    input  logic  flush_req_i,
    output logic  flush_ack_o,
    input  logic  flush_done_i,
    output logic  aw_gate_o,
    output logic  ar_gate_o,
    output desc_t desc_o,
    output logic  desc_valid_o,
    input  logic  desc_ready_i
);

    sched_state_e state_q, state_d;
    sched_src_e   lock_q, lock_d;
    sched_src_e   sel;
    logic         prio_q, prio_d;
    logic         hs;
    logic         drained;

    // Source select and zero-latency descriptor mux.
    always_comb begin
        sel           = SRC_NONE;
        desc_o        = '0;
        desc_valid_o  = 1'b0;
        aw_ready_o    = 1'b0;
        ar_ready_o    = 1'b0;
        flush_ready_o = 1'b0;
        if (state_q == FLUSH) begin
            sel = SRC_FLUSH;
        end else if (lock_q != SRC_NONE) begin
            sel = lock_q;
        end else if (aw_valid_i && ar_valid_i) begin
            sel = prio_q ? SRC_AW : SRC_AR;
        end else if (aw_valid_i) begin
            sel = SRC_AW;
        end else if (ar_valid_i) begin
            sel = SRC_AR;
        end
        case (sel)
            SRC_AW: begin
                desc_o       = aw_desc_i;
                desc_valid_o = aw_valid_i;
                aw_ready_o   = desc_ready_i;
            end
            SRC_AR: begin
                desc_o       = ar_desc_i;
                desc_valid_o = ar_valid_i;
                ar_ready_o   = desc_ready_i;
            end
            SRC_FLUSH: begin
                desc_o        = flush_desc_i;
                desc_valid_o  = flush_valid_i;
                flush_ready_o = desc_ready_i;
            end
            default: ;
        endcase
    end

    assign hs      = desc_valid_o & desc_ready_i;
    assign drained = !aw_busy_i && !ar_busy_i && (lock_q == SRC_NONE)
                     && !aw_valid_i && !ar_valid_i;

    // Next-state: burst lock, round-robin pointer and flush sequencing.
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        prio_d  = prio_q;
        if (hs && (sel == SRC_AW || sel == SRC_AR)) begin
            if (desc_o.x_last) begin
                lock_d = SRC_NONE;
                prio_d = (sel == SRC_AR);
            end else begin
                lock_d = sel;
            end
        end
        case (state_q)
            RUN: begin
                if (flush_req_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (!flush_req_i) state_d = RUN;
                else if (drained) state_d = FLUSH;
            end
            FLUSH: begin
                if (flush_done_i) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
            lock_q  <= SRC_NONE;
            prio_q  <= RrInitAw;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            prio_q  <= prio_d;
        end
    end

    assign aw_gate_o   = (state_q != RUN);
    assign ar_gate_o   = (state_q != RUN);
    assign flush_ack_o = (state_q == FLUSH);

endmodule

// File: tb/tb_axi_llc_desc_scheduler.sv
// Randomized bench for the descriptor scheduler against a
// transaction-level reference model of arbitration and flush phases.
module tb_axi_llc_desc_scheduler;
    import axi_llc_pkg::*;

    logic      clk = 1'b0;
    logic      rst_i;
    llc_desc_t aw_desc_i, ar_desc_i, flush_desc_i, desc_o;
    logic      aw_valid_i, aw_ready_o, aw_busy_i;
    logic      ar_valid_i, ar_ready_o, ar_busy_i;
    logic      flush_valid_i, flush_ready_o, flush_req_i, flush_ack_o;
    logic      flush_done_i, aw_gate_o, ar_gate_o, desc_valid_o, desc_ready_i;

    always #5 clk = ~clk;

    axi_llc_desc_scheduler #(
        .desc_t   (llc_desc_t),
        .RrInitAw (1'b1)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .aw_desc_i     (aw_desc_i),
        .aw_valid_i    (aw_valid_i),
        .aw_ready_o    (aw_ready_o),
        .aw_busy_i     (aw_busy_i),
        .ar_desc_i     (ar_desc_i),
        .ar_valid_i    (ar_valid_i),
        .ar_ready_o    (ar_ready_o),
        .ar_busy_i     (ar_busy_i),
        .flush_desc_i  (flush_desc_i),
        .flush_valid_i (flush_valid_i),
        .flush_ready_o (flush_ready_o),
        .flush_req_i   (flush_req_i),
        .flush_ack_o   (flush_ack_o),
        .flush_done_i  (flush_done_i),
        .aw_gate_o     (aw_gate_o),
        .ar_gate_o     (ar_gate_o),
        .desc_o        (desc_o),
        .desc_valid_o  (desc_valid_o),
        .desc_ready_i  (desc_ready_i)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0 normal, 1 draining, 2 flush window.
    // owner: source holding an unfinished burst (-1 none, 0 AW, 1 AR).
    // turn: source that wins a tie (0 AW, 1 AR).
    int m_phase, m_owner, m_turn;
    int fl_cnt;
    int n_aw, n_ar, n_fl, n_flushes;

    // Producer (splitter) state: pending descriptor, mid-burst flag.
    logic      p_pend[2];
    logic      p_inburst[2];
    llc_desc_t p_desc[2];

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic llc_desc_t mk_desc(int src, logic last);
        llc_desc_t d;
        d.addr   = 16'($urandom);
        d.id     = 4'(src + 1);
        d.rw     = (src == 0);
        d.x_last = last;
        return d;
    endfunction

    task automatic model_reset();
        m_phase   = 0;
        m_owner   = -1;
        m_turn    = 0;
        fl_cnt    = 0;
        for (int s = 0; s < 2; s++) begin
            p_pend[s]    = 1'b0;
            p_inburst[s] = 1'b0;
            p_desc[s]    = '0;
        end
    endtask

    // One cycle: called at negedge with non-AX inputs set by caller.
    task automatic step();
        int        sel;
        logic      ev;
        logic      hs;
        logic      idle;
        llc_desc_t ed;
        aw_valid_i = p_pend[0];
        aw_desc_i  = p_desc[0];
        ar_valid_i = p_pend[1];
        ar_desc_i  = p_desc[1];
        #1;
        if (m_phase == 2)
            sel = 2;
        else if (m_owner >= 0)
            sel = m_owner;
        else if (p_pend[0] && p_pend[1])
            sel = m_turn;
        else if (p_pend[0])
            sel = 0;
        else if (p_pend[1])
            sel = 1;
        else
            sel = -1;
        ev = 1'b0;
        ed = '0;
        if (sel == 2) begin
            ev = flush_valid_i;
            ed = flush_desc_i;
        end else if (sel >= 0) begin
            ev = p_pend[sel];
            ed = p_desc[sel];
        end
        check("aw_ready", 64'(aw_ready_o), 64'(sel == 0 && desc_ready_i));
        check("ar_ready", 64'(ar_ready_o), 64'(sel == 1 && desc_ready_i));
        check("flush_ready", 64'(flush_ready_o), 64'(sel == 2 && desc_ready_i));
        check("desc_valid", 64'(desc_valid_o), 64'(ev));
        if (ev) check("desc", 64'(desc_o), 64'(ed));
        check("aw_gate", 64'(aw_gate_o), 64'(m_phase != 0));
        check("ar_gate", 64'(ar_gate_o), 64'(m_phase != 0));
        check("flush_ack", 64'(flush_ack_o), 64'(m_phase == 2));
        hs   = ev && desc_ready_i;
        idle = !aw_busy_i && !ar_busy_i && m_owner < 0 && !p_pend[0] && !p_pend[1];
        @(posedge clk);
        if (hs && sel < 2) begin
            if (sel == 0) n_aw++;
            else n_ar++;
            p_pend[sel]    = 1'b0;
            p_inburst[sel] = !p_desc[sel].x_last;
            if (p_desc[sel].x_last) begin
                m_owner = -1;
                m_turn  = 1 - sel;
            end else begin
                m_owner = sel;
            end
        end
        if (hs && sel == 2) begin
            fl_cnt++;
            n_fl++;
        end
        case (m_phase)
            0: if (flush_req_i) m_phase = 1;
            1: begin
                if (!flush_req_i) m_phase = 0;
                else if (idle) begin
                    m_phase = 2;
                    n_flushes++;
                end
            end
            default: if (flush_done_i) m_phase = 0;
        endcase
        if (m_phase != 2) fl_cnt = 0;
        @(negedge clk);
    endtask

    // Asynchronous reset in the middle of a cycle, then resume.
    task automatic mid_reset();
        desc_ready_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_ack", 64'(flush_ack_o), 64'(0));
        check("rst_aw_gate", 64'(aw_gate_o), 64'(0));
        check("rst_ar_gate", 64'(ar_gate_o), 64'(0));
        check("rst_aw_ready", 64'(aw_ready_o), 64'(0));
        check("rst_ar_ready", 64'(ar_ready_o), 64'(0));
        check("rst_flush_ready", 64'(flush_ready_o), 64'(0));
        check("rst_valid", 64'(desc_valid_o), 64'(aw_valid_i | ar_valid_i));
        @(posedge clk);
        @(negedge clk);
        rst_i        = 1'b0;
        flush_req_i  = 1'b0;
        flush_done_i = 1'b0;
        model_reset();
    endtask

    task automatic rand_inputs();
        for (int s = 0; s < 2; s++) begin
            if (!p_pend[s] && (m_phase == 0 || p_inburst[s])
                && $urandom_range(0, 2) == 0) begin
                p_pend[s] = 1'b1;
                p_desc[s] = mk_desc(s, $urandom_range(0, 2) == 0);
            end
        end
        aw_busy_i    = p_pend[0] | p_inburst[0] | ($urandom_range(0, 4) == 0);
        ar_busy_i    = p_pend[1] | p_inburst[1] | ($urandom_range(0, 4) == 0);
        desc_ready_i = ($urandom_range(0, 3) != 0);
        flush_desc_i = mk_desc(2, 1'($urandom));
        flush_valid_i = 1'($urandom);
        flush_done_i = 1'b0;
        if (m_phase == 2) begin
            if (fl_cnt >= 4 && $urandom_range(0, 2) == 0) begin
                flush_done_i = 1'b1;
                flush_req_i  = 1'b0;
            end
        end else begin
            flush_done_i = ($urandom_range(0, 15) == 0);
            if (!flush_req_i) flush_req_i = ($urandom_range(0, 19) == 0);
            else if ($urandom_range(0, 29) == 0) flush_req_i = 1'b0;
        end
    endtask

    initial begin
        n_aw = 0;
        n_ar = 0;
        n_fl = 0;
        n_flushes = 0;
        model_reset();
        rst_i         = 1'b1;
        aw_desc_i     = '0;
        ar_desc_i     = '0;
        flush_desc_i  = '0;
        aw_valid_i    = 1'b0;
        ar_valid_i    = 1'b0;
        aw_busy_i     = 1'b0;
        ar_busy_i     = 1'b0;
        flush_valid_i = 1'b0;
        flush_req_i   = 1'b0;
        flush_done_i  = 1'b0;
        desc_ready_i  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_valid", 64'(desc_valid_o), 64'(0));
        check("reset_ack", 64'(flush_ack_o), 64'(0));
        check("reset_gates", 64'({aw_gate_o, ar_gate_o}), 64'(0));
        check("reset_readies", 64'({aw_ready_o, ar_ready_o, flush_ready_o}), 64'(0));
        rst_i = 1'b0;

        // AW burst of three plus one AR, both valid: AW,AW,AW,AR.
        desc_ready_i = 1'b1;
        p_pend[1] = 1'b1;
        p_desc[1] = mk_desc(1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                p_pend[0] = 1'b1;
                p_desc[0] = mk_desc(0, k == 2);
            end
            step();
            check("rr_seq_src", 64'(k < 3 ? n_aw : n_ar), 64'(k < 3 ? k + 1 : 1));
        end
        // Both valid again: AW has priority after the AR burst.
        p_pend[0] = 1'b1;
        p_desc[0] = mk_desc(0, 1'b1);
        p_pend[1] = 1'b1;
        p_desc[1] = mk_desc(1, 1'b1);
        step();
        check("rr_prio_aw", 64'(n_aw), 64'(4));
        step();

        // Lock AW mid-burst, then reset with downstream stalled.
        p_pend[0] = 1'b1;
        p_desc[0] = mk_desc(0, 1'b0);
        step();
        p_pend[0] = 1'b1;
        p_desc[0] = mk_desc(0, 1'b0);
        mid_reset();

        for (int i = 0; i < 4000; i++) begin
            if (i == 1500 || i == 3000) mid_reset();
            rand_inputs();
            step();
        end

        check("saw_flush_windows", 64'(n_flushes > 3), 64'(1));
        check("saw_flush_descs", 64'(n_fl > 10), 64'(1));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
